// File: rtl/tile_map_pkg.sv
// Default VGA timing and tile geometry shared by the tile/display coordinate mapper.
// Derived widths follow from the defaults so a retarget only touches the base constants.
package tile_map_pkg;

  localparam int H_START_D    = 336;
  localparam int V_START_D    = 27;
  localparam int H_VIS_D      = 1280;
  localparam int V_VIS_D      = 800;
  localparam int TILE_SHIFT_D = 4;
  localparam int COLS_D       = H_VIS_D >> TILE_SHIFT_D;
  localparam int ROWS_D       = V_VIS_D >> TILE_SHIFT_D;

  localparam int HW_D  = 11;
  localparam int VW_D  = 10;
  localparam int IXW_D = $clog2(COLS_D);
  localparam int IYW_D = $clog2(ROWS_D);
  localparam int AW_D  = $clog2(COLS_D * ROWS_D);

  typedef enum logic {
    ANCHOR_TL  = 1'b0,
    ANCHOR_CTR = 1'b1
  } anchor_e;

  // Pixel offset from the tile's top-left corner to its (upper-left) centre pixel.
  function automatic int centre_off(input int shift);
    return (1 << (shift - 1)) - 1;
  endfunction

endpackage

// File: rtl/tile_scan_addr.sv
// Two-stage scan pipeline: live (hcount, vcount) -> tile index, in-tile offset and
// linear tile-map address, with the row base accumulated line by line (no multiplier).
module tile_scan_addr
  import tile_map_pkg::*;
#(
  parameter int H_START    = H_START_D,
  parameter int V_START    = V_START_D,
  parameter int H_VIS      = H_VIS_D,
  parameter int V_VIS      = V_VIS_D,
  parameter int TILE_SHIFT = TILE_SHIFT_D,
  parameter int COLS       = COLS_D,
  parameter int HW         = HW_D,
  parameter int VW         = VW_D,
  parameter int IXW        = IXW_D,
  parameter int IYW        = IYW_D,
  parameter int AW         = AW_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_valid_i,
  input  logic [HW-1:0]         pix_hcount_i,
  input  logic [VW-1:0]         pix_vcount_i,
  output logic                  scan_valid_o,
  output logic                  scan_visible_o,
  output logic [IXW-1:0]        scan_tile_x_o,
  output logic [IYW-1:0]        scan_tile_y_o,
  output logic [TILE_SHIFT-1:0] scan_off_x_o,
  output logic [TILE_SHIFT-1:0] scan_off_y_o,
  output logic [AW-1:0]         scan_addr_o
);

  localparam logic [HW-1:0] HS     = HW'(H_START);
  localparam logic [HW-1:0] HE     = HW'(H_START + H_VIS - 1);
  localparam logic [VW-1:0] VS     = VW'(V_START);
  localparam logic [VW-1:0] VE     = VW'(V_START + V_VIS - 1);
  localparam logic [AW-1:0] COLS_A = AW'(COLS);

  logic [HW-1:0]         rel_x;
  logic [VW-1:0]         rel_y;
  logic                  vis;
  logic                  line_start;
  logic [1:0]            vld_pipe_q;
  logic [AW-1:0]         row_base_q, row_base_d;
  logic                  s1_vis_q;
  logic [IXW-1:0]        s1_tx_q;
  logic [IYW-1:0]        s1_ty_q;
  logic [TILE_SHIFT-1:0] s1_ox_q, s1_oy_q;
  logic                  vis_q;
  logic [IXW-1:0]        tx_q;
  logic [IYW-1:0]        ty_q;
  logic [TILE_SHIFT-1:0] ox_q, oy_q;
  logic [AW-1:0]         addr_q;

  always_comb begin
    rel_x      = pix_hcount_i - HS;
    rel_y      = pix_vcount_i - VS;
    vis        = (pix_hcount_i >= HS) && (pix_hcount_i <= HE) &&
                 (pix_vcount_i >= VS) && (pix_vcount_i <= VE);
    line_start = pix_valid_i && vis && (pix_hcount_i == HS);
    row_base_d = row_base_q;
    // Advance by one tile row only on the first line of each tile row.
    if (line_start) begin
      if (pix_vcount_i == VS)
        row_base_d = '0;
      else if (rel_y[TILE_SHIFT-1:0] == '0)
        row_base_d = row_base_q + COLS_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      row_base_q <= '0;
      s1_vis_q   <= 1'b0;
      s1_tx_q    <= '0;
      s1_ty_q    <= '0;
      s1_ox_q    <= '0;
      s1_oy_q    <= '0;
      vis_q      <= 1'b0;
      tx_q       <= '0;
      ty_q       <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      addr_q     <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[0], pix_valid_i};
      row_base_q <= row_base_d;
      if (pix_valid_i) begin
        s1_vis_q <= vis;
        s1_tx_q  <= rel_x[TILE_SHIFT +: IXW];
        s1_ty_q  <= rel_y[TILE_SHIFT +: IYW];
        s1_ox_q  <= rel_x[TILE_SHIFT-1:0];
        s1_oy_q  <= rel_y[TILE_SHIFT-1:0];
      end
      // row_base_q already reflects this pixel's line when stage 2 samples it.
      if (vld_pipe_q[0]) begin
        vis_q  <= s1_vis_q;
        tx_q   <= s1_vis_q ? s1_tx_q : '0;
        ty_q   <= s1_vis_q ? s1_ty_q : '0;
        ox_q   <= s1_vis_q ? s1_ox_q : '0;
        oy_q   <= s1_vis_q ? s1_oy_q : '0;
        addr_q <= s1_vis_q ? (row_base_q + AW'(s1_tx_q)) : '0;
      end
    end
  end

  assign scan_valid_o   = vld_pipe_q[1];
  assign scan_visible_o = vis_q;
  assign scan_tile_x_o  = tx_q;
  assign scan_tile_y_o  = ty_q;
  assign scan_off_x_o   = ox_q;
  assign scan_off_y_o   = oy_q;
  assign scan_addr_o    = addr_q;

endmodule

// File: rtl/tile_coord_mapper.sv
// Bidirectional tile-matrix <-> VGA coordinate mapper: a one-deep registered request
// path (index -> display position) plus the pipelined scan path (position -> tile).
module tile_coord_mapper
  import tile_map_pkg::*;
#(
  parameter int H_START    = H_START_D,
  parameter int V_START    = V_START_D,
  parameter int H_VIS      = H_VIS_D,
  parameter int V_VIS      = V_VIS_D,
  parameter int TILE_SHIFT = TILE_SHIFT_D,
  parameter int COLS       = COLS_D,
  parameter int ROWS       = ROWS_D,
  parameter int HW         = HW_D,
  parameter int VW         = VW_D,
  parameter int IXW        = IXW_D,
  parameter int IYW        = IYW_D,
  parameter int AW         = AW_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [IXW-1:0]        req_idx_x,
  input  logic [IYW-1:0]        req_idx_y,
  input  logic                  req_anchor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [HW-1:0]         rsp_pos_x,
  output logic [VW-1:0]         rsp_pos_y,
  output logic                  rsp_err,
  input  logic                  pix_valid,
  input  logic [HW-1:0]         pix_hcount,
  input  logic [VW-1:0]         pix_vcount,
  output logic                  scan_valid,
  output logic                  scan_visible,
  output logic [IXW-1:0]        scan_tile_x,
  output logic [IYW-1:0]        scan_tile_y,
  output logic [TILE_SHIFT-1:0] scan_off_x,
  output logic [TILE_SHIFT-1:0] scan_off_y,
  output logic [AW-1:0]         scan_addr
);

  localparam logic [HW-1:0]  HS     = HW'(H_START);
  localparam logic [VW-1:0]  VS     = VW'(V_START);
  localparam logic [HW-1:0]  CX     = HW'(centre_off(TILE_SHIFT));
  localparam logic [VW-1:0]  CY     = VW'(centre_off(TILE_SHIFT));
  localparam logic [IXW:0]   COLS_W = (IXW+1)'(COLS);
  localparam logic [IYW:0]   ROWS_W = (IYW+1)'(ROWS);

  logic          accept;
  logic          oor;
  logic          rsp_valid_q, rsp_valid_d;
  logic [HW-1:0] pos_x_q, pos_x_d;
  logic [VW-1:0] pos_y_q, pos_y_d;
  logic          err_q, err_d;

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign oor       = ({1'b0, req_idx_x} >= COLS_W) || ({1'b0, req_idx_y} >= ROWS_W);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    err_d       = err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      err_d       = oor;
      if (oor) begin
        pos_x_d = HS;
        pos_y_d = VS;
      end else begin
        pos_x_d = HS + (HW'(req_idx_x) << TILE_SHIFT) +
                  ((req_anchor == ANCHOR_CTR) ? CX : '0);
        pos_y_d = VS + (VW'(req_idx_y) << TILE_SHIFT) +
                  ((req_anchor == ANCHOR_CTR) ? CY : '0);
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_pos_x = pos_x_q;
  assign rsp_pos_y = pos_y_q;
  assign rsp_err   = err_q;

  tile_scan_addr #(
    .H_START(H_START), .V_START(V_START), .H_VIS(H_VIS), .V_VIS(V_VIS),
    .TILE_SHIFT(TILE_SHIFT), .COLS(COLS), .HW(HW), .VW(VW),
    .IXW(IXW), .IYW(IYW), .AW(AW)
  ) u_scan (
    .clk           (clk),
    .rst_n         (rst_n),
    .pix_valid_i   (pix_valid),
    .pix_hcount_i  (pix_hcount),
    .pix_vcount_i  (pix_vcount),
    .scan_valid_o  (scan_valid),
    .scan_visible_o(scan_visible),
    .scan_tile_x_o (scan_tile_x),
    .scan_tile_y_o (scan_tile_y),
    .scan_off_x_o  (scan_off_x),
    .scan_off_y_o  (scan_off_y),
    .scan_addr_o   (scan_addr)
  );

endmodule

// File: doc/tile_coord_mapper.md
# tile_coord_mapper

Bidirectional, parametrised mapper between the tile matrix and VGA display coordinates. It sits between the VGA timing generator and the game/render logic. The request path turns a matrix index into a display position; the scan path turns the live scan position into a tile index, an in-tile offset and a linear tile-map address. Both paths are pipelined, use no multiplier or divider, and map tile size as a power-of-two shift.

## Interface
Parameters:
- H_START, 336, first visible horizontal count
- V_START, 27, first visible vertical count
- H_VIS, 1280, visible width in pixels
- V_VIS, 800, visible height in pixels
- TILE_SHIFT, 4, log2 of tile edge in pixels; must be ≥1
- COLS, 80, matrix columns; must equal H_VIS>>TILE_SHIFT
- ROWS, 50, matrix rows; must equal V_VIS>>TILE_SHIFT
- HW, 11, horizontal count width
- VW, 10, vertical count width
- IXW, 7, column index width
- IYW, 6, row index width
- AW, 12, tile-map address width; must satisfy 2^AW ≥ COLS*ROWS

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  index request valid
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_idx_x  in  IXW  column index
- req_idx_y  in  IYW  row index
- req_anchor  in  1  0 = tile top-left pixel, 1 = tile centre
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_pos_x  out  HW  display horizontal count
- rsp_pos_y  out  VW  display vertical count
- rsp_err  out  1  requested index out of range
- pix_valid  in  1  one pulse per pixel from the timing generator
- pix_hcount  in  HW  current horizontal count
- pix_vcount  in  VW  current vertical count
- scan_valid  out  1  scan outputs valid, 2 cycles after pix_valid
- scan_visible  out  1  pixel inside visible window
- scan_tile_x  out  IXW  tile column
- scan_tile_y  out  IYW  tile row
- scan_off_x  out  TILE_SHIFT  pixel offset inside tile
- scan_off_y  out  TILE_SHIFT  line offset inside tile
- scan_addr  out  AW  tile_y*COLS + tile_x

## Operation
- All outputs reset to 0. The request output register is empty and row_base is 0.
- Request path:
  - Single output register.
  - req_ready = !rsp_valid || rsp_ready.
  - On accept, compute rsp_pos_x = H_START + (idx_x<<TILE_SHIFT) + C and rsp_pos_y = V_START + (idx_y<<TILE_SHIFT) + C.
  - C = 0 when req_anchor is 0, and C = (1<<(TILE_SHIFT-1))-1 when req_anchor is 1.
  - Perform the addition in HW and VW widths with explicit zero-extension. Shift before adding.
  - If idx_x≥COLS or idx_y≥ROWS, set rsp_err=1 and force the position to (H_START, V_START).
  - The response holds stable while rsp_valid && !rsp_ready.
- Scan path, stage 1 (registered):
  - rel_x = hcount−H_START, rel_y = vcount−V_START.
  - visible = hcount in [H_START, H_START+H_VIS−1] and vcount in [V_START, V_START+V_VIS−1].
  - Tile and offset are the high and low slices of rel_x and rel_y.
  - row_base update on a visible pixel with hcount==H_START:
    - If vcount==V_START, row_base←0.
    - Else if rel_y[TILE_SHIFT−1:0]==0, row_base←row_base+COLS.
    - Otherwise hold.
- Scan path, stage 2 (registered):
  - scan_addr = row_base + tile_x, using the row_base value already updated for this line.
  - When not visible, tile, offset and addr outputs are 0 and scan_visible=0. scan_valid still follows pix_valid.
- Without pix_valid the stage registers hold; scan_valid is 0.

## Timing
- Request latency is 1 cycle from accept to rsp_valid. Full throughput is one request per cycle while rsp_ready=1.
- Simultaneous accept and drain replaces the response in the same cycle, with no bubble.
- Scan latency is exactly 2 cycles, pix_valid → scan_valid. The path has no backpressure.
- row_base relies on the generator visiting hcount==H_START on every visible line. A frame entered mid-way yields wrong addresses until the next vcount==V_START line.
- Reset asserted mid-operation:
  - Clears rsp_valid immediately. The pending response is dropped.
  - Clears the scan pipeline and row_base asynchronously.
  - Release is synchronous to clk as usual.

## Structure
- Package tile_map_pkg holds the default timing constants (H_START, V_START, H_VIS, V_VIS, TILE_SHIFT, COLS, ROWS) and derived widths; the top-level parameters default from it.
- Sub-module tile_scan_addr contains the two-stage scan pipeline and row_base. The request path stays in the top-level.

## Test plan
- Request (0,0,anchor=1) with rsp_ready=1 → next cycle rsp_pos=(343,34), rsp_err=0.
- Request (79,49,anchor=0) → rsp_pos=(1600,811); request (79,49,anchor=1) → (1607,818).
- Request (80,0) → rsp_err=1, rsp_pos=(336,27); request (0,50) → rsp_err=1.
- Backpressure:
  - Hold rsp_ready=0 after one response → req_ready=0 and the response stays stable.
  - A second req_valid is not lost; it appears the cycle after rsp_ready rises.
- Full-frame scan sweep:
  - At hcount=353, vcount=60 → 2 cycles later tile=(1,2), off=(1,1), addr=161.
  - At the last visible pixel → addr=3999.
  - hcount=335 → scan_visible=0 and all outputs 0.
- Reset asserted mid-frame and mid-response:
  - Outputs go to 0 immediately.
  - After release, the next frame from vcount=27 gives addr=0 at the first pixel.
